led_vu_meter: RTL and testbench



---
 rtl/eq_led_pkg.sv | 61 ++++++
 rtl/vu_chan.sv | 109 ++++++++++
 rtl/led_vu_meter.sv | 134 +++++++++++++
 tb/tb_led_vu_meter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_led_pkg.sv
// Shared types, thresholds and sample arithmetic for the stereo LED VU meter.
// Used by vu_chan and led_vu_meter.
package eq_led_pkg;

   typedef logic [2:0]  level_t;   // bar or hold level, 0..4
   typedef logic [14:0] abs_t;     // sample magnitude
   typedef logic [3:0]  seg_t;     // one 4-segment bar

   localparam int NUM_SEG = 4;
   localparam abs_t THR [0:3] = '{15'd2048, 15'd4096, 15'd8192, 15'd16384};

   // |s| as 15 bits; the one magnitude that does not fit (-32768) saturates.
   function automatic abs_t abs_sat(input logic signed [15:0] s);
      logic [15:0] mag;
      mag = s[15] ? 16'(-s) : 16'(s);
      return mag[15] ? 15'h7FFF : mag[14:0];
   endfunction

   // A geometric decay step that still reaches zero once the shifted step vanishes.
   function automatic abs_t dec_peak(input abs_t p, input int unsigned shift);
      abs_t step;
      step = p >> shift;
      if (step != '0) begin
         return p - step;
      end else if (p != '0) begin
         return p - 15'd1;
      end
      return p;
   endfunction

   function automatic seg_t therm(input abs_t p);
      seg_t t;
      t = '0;
      for (int i = 0; i < NUM_SEG; i++) begin
         t[i] = (p >= THR[i]);
      end
      return t;
   endfunction

   function automatic level_t seg_level(input seg_t s);
      level_t lvl;
      lvl = '0;
      for (int i = 0; i < NUM_SEG; i++) begin
         lvl = lvl + level_t'(s[i]);
      end
      return lvl;
   endfunction

   function automatic seg_t hold_dot(input level_t h);
      seg_t d;
      case (h)
         3'd1:    d = 4'b0001;
         3'd2:    d = 4'b0010;
         3'd3:    d = 4'b0100;
         3'd4:    d = 4'b1000;
         default: d = 4'b0000;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/vu_chan.sv
// One meter channel: magnitude capture, decaying peak, thermometer bar and,
// with LED_PEAK_HOLD_EN, a peak-hold dot.
module vu_chan
   import eq_led_pkg::*;
#(
   parameter int unsigned DECAY_SHIFT = 3
`ifdef LED_PEAK_HOLD_EN
   , parameter int unsigned HOLD_SMPLS = 12288
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cap,
   input  logic signed [15:0] smp,
   input  logic               upd,
   input  logic               dec_evt,
`ifdef LED_PEAK_HOLD_EN
   input  logic               adv,
`endif
   input  logic               blank,
   output seg_t               seg
);

   abs_t abs_d, abs_q;
   abs_t peak_d, peak_q;
   abs_t peak_base;
   seg_t seg_d, seg_q;

   always_comb begin
      abs_d = abs_q;
      if (cap) begin
         abs_d = abs_sat(smp);
      end
   end

   // The decay is applied before the max so a loud sample on a decay event wins.
   always_comb begin
      peak_base = dec_evt ? dec_peak(peak_q, DECAY_SHIFT) : peak_q;
      peak_d    = peak_q;
      if (blank) begin
         peak_d = '0;
      end else if (upd) begin
         peak_d = (abs_q > peak_base) ? abs_q : peak_base;
      end
   end

`ifdef LED_PEAK_HOLD_EN
   localparam int unsigned HCW = $clog2(HOLD_SMPLS + 1);
   localparam logic [HCW-1:0] HOLD_RELOAD = HCW'(HOLD_SMPLS);

   level_t         hold_d, hold_q;
   level_t         bar_lvl;
   logic [HCW-1:0] hcnt_d, hcnt_q;

   always_comb begin
      hold_d  = hold_q;
      hcnt_d  = hcnt_q;
      bar_lvl = seg_level(therm(peak_q));
      if (blank) begin
         hold_d = '0;
         hcnt_d = '0;
      end else if (adv) begin
         if (bar_lvl > hold_q) begin
            hold_d = bar_lvl;
            hcnt_d = HOLD_RELOAD;
         end else if (hcnt_q == '0) begin
            if (hold_q != '0) begin
               hold_d = hold_q - 3'd1;
            end
            hcnt_d = HOLD_RELOAD;
         end else begin
            hcnt_d = hcnt_q - HCW'(1);
         end
      end
      seg_d = blank ? '0 : (therm(peak_q) | hold_dot(hold_d));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         hcnt_q <= '0;
      end else begin
         hold_q <= hold_d;
         hcnt_q <= hcnt_d;
      end
   end
`else
   always_comb begin
      seg_d = blank ? '0 : therm(peak_q);
   end
`endif

   // NOTE: non-blocking assignments here so every stage samples its inputs
   // before any register in the pipeline updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         abs_q  <= '0;
         peak_q <= '0;
         seg_q  <= '0;
      end else begin
         abs_q  <= abs_d;
         peak_q <= peak_d;
         seg_q  <= seg_d;
      end
   end

   assign seg = seg_q;

endmodule

// File: rtl/led_vu_meter.sv
// Stereo VU meter driving LED[7:4] (left) and LED[3:0] (right) as bars.
// Define LED_PEAK_HOLD_EN to add a per-channel peak-hold dot.
module led_vu_meter
   import eq_led_pkg::*;
#(
   parameter int unsigned DECAY_SMPLS = 256,
   parameter int unsigned DECAY_SHIFT = 3,
   parameter int unsigned IDLE_CLKS   = 1048576
`ifdef LED_PEAK_HOLD_EN
   , parameter int unsigned HOLD_SMPLS = 12288
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   input  logic signed [15:0] lft_out,
   input  logic signed [15:0] rht_out,
   output logic [7:0]         LED
);

   localparam int unsigned DCW = (DECAY_SMPLS > 1) ? $clog2(DECAY_SMPLS) : 1;
   localparam int unsigned ICW = (IDLE_CLKS > 1) ? $clog2(IDLE_CLKS) : 1;
   localparam logic [DCW-1:0] DEC_LAST  = DCW'(DECAY_SMPLS - 1);
   localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CLKS - 1);

   logic           valid_d, valid_q;
   logic           strobe;
   logic           dec_evt;
   logic           blank;
   logic [DCW-1:0] dcnt_d, dcnt_q;
   logic [ICW-1:0] idle_d, idle_q;
   logic           s1_vld_d, s1_vld_q;
   logic           s1_dec_d, s1_dec_q;
`ifdef LED_PEAK_HOLD_EN
   logic           s2_vld_d, s2_vld_q;
`endif
   seg_t           seg_l, seg_r;

   always_comb begin
      valid_d  = valid;
      strobe   = valid & ~valid_q;
      dec_evt  = strobe & (dcnt_q == DEC_LAST);
      s1_vld_d = strobe;
      s1_dec_d = dec_evt;
`ifdef LED_PEAK_HOLD_EN
      s2_vld_d = s1_vld_q;
`endif
   end

   always_comb begin
      dcnt_d = dcnt_q;
      if (strobe) begin
         dcnt_d = dec_evt ? '0 : dcnt_q + DCW'(1);
      end
   end

   // A strobe arriving on the saturating cycle keeps the meter alive.
   always_comb begin
      blank  = ~strobe & (idle_q == IDLE_LAST);
      idle_d = idle_q;
      if (strobe) begin
         idle_d = '0;
      end else if (idle_q != IDLE_LAST) begin
         idle_d = idle_q + ICW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         dcnt_q   <= '0;
         idle_q   <= '0;
         s1_vld_q <= 1'b0;
         s1_dec_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         dcnt_q   <= dcnt_d;
         idle_q   <= idle_d;
         s1_vld_q <= s1_vld_d;
         s1_dec_q <= s1_dec_d;
      end
   end

`ifdef LED_PEAK_HOLD_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld_q <= 1'b0;
      end else begin
         s2_vld_q <= s2_vld_d;
      end
   end
`endif

   vu_chan #(
      .DECAY_SHIFT (DECAY_SHIFT)
`ifdef LED_PEAK_HOLD_EN
      , .HOLD_SMPLS (HOLD_SMPLS)
`endif
   ) u_left (
      .clk     (clk),
      .rst     (rst),
      .cap     (strobe),
      .smp     (lft_out),
      .upd     (s1_vld_q),
      .dec_evt (s1_dec_q),
`ifdef LED_PEAK_HOLD_EN
      .adv     (s2_vld_q),
`endif
      .blank   (blank),
      .seg     (seg_l)
   );

   vu_chan #(
      .DECAY_SHIFT (DECAY_SHIFT)
`ifdef LED_PEAK_HOLD_EN
      , .HOLD_SMPLS (HOLD_SMPLS)
`endif
   ) u_right (
      .clk     (clk),
      .rst     (rst),
      .cap     (strobe),
      .smp     (rht_out),
      .upd     (s1_vld_q),
      .dec_evt (s1_dec_q),
`ifdef LED_PEAK_HOLD_EN
      .adv     (s2_vld_q),
`endif
      .blank   (blank),
      .seg     (seg_r)
   );

   assign LED = {seg_l, seg_r};

endmodule

// File: tb/tb_led_vu_meter.sv
// Self-checking bench for led_vu_meter: event-level reference model compared
// every cycle, plus directed literal expectations.
module tb_led_vu_meter;

   localparam int DECAY_SMPLS = 256;
   localparam int IDLE_CLKS   = 64;

   logic               clk = 1'b0;
   logic               rst;
   logic               valid;
   logic signed [15:0] lft_out;
   logic signed [15:0] rht_out;
   logic [7:0]         LED;

   led_vu_meter #(
      .DECAY_SMPLS (DECAY_SMPLS),
      .DECAY_SHIFT (3),
      .IDLE_CLKS   (IDLE_CLKS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid),
      .lft_out (lft_out),
      .rht_out (rht_out),
      .LED     (LED)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: per accepted sample, from the meter's rules.
   typedef struct {
      int         t;
      logic [7:0] v;
   } ev_t;

   ev_t        sched[$];
   int         lhist[$];
   int         nsmp = 0, quiet = 0, lpk = 0, rpk = 0;
   bit         vprev = 1'b0, started = 1'b0, stb, dec;
   logic [7:0] exp_led = 8'h00;

   function automatic int mag(input logic signed [15:0] s);
      int x;
      x = int'(s);
      if (x < 0) x = -x;
      return (x > 32767) ? 32767 : x;
   endfunction

   function automatic int decay(input int p);
      if ((p >> 3) != 0) return p - (p >> 3);
      if (p != 0) return p - 1;
      return 0;
   endfunction

   function automatic int maxi(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [3:0] bar(input int p);
      logic [3:0] b;
      for (int i = 0; i < 4; i++) b[i] = (p >= (2048 << i));
      return b;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         started = 1'b1;
         vprev   = 1'b0;
         nsmp    = 0;
         quiet   = 0;
         lpk     = 0;
         rpk     = 0;
         sched.delete();
         sched.push_back('{t: cyc + 1, v: 8'h00});
      end else begin
         stb   = valid && !vprev;
         vprev = valid;
         if (stb) begin
            nsmp++;
            dec = (nsmp % DECAY_SMPLS) == 0;
            lpk = maxi(dec ? decay(lpk) : lpk, mag(lft_out));
            rpk = maxi(dec ? decay(rpk) : rpk, mag(rht_out));
            if (dec) lhist.push_back(lpk);
            quiet = 0;
            sched.push_back('{t: cyc + 3, v: {bar(lpk), bar(rpk)}});
         end else begin
            quiet++;
            if (quiet >= IDLE_CLKS) begin
               lpk = 0;
               rpk = 0;
               sched.push_back('{t: cyc + 1, v: 8'h00});
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      while (sched.size() > 0 && sched[0].t <= cyc) exp_led = sched.pop_front().v;
      if (started) check("led_model", LED, exp_led);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int l, input int r, input int hi, input int lo);
      valid   = 1'b1;
      lft_out = 16'(l);
      rht_out = 16'(r);
      step(hi);
      valid   = 1'b0;
      lft_out = 16'($urandom);
      rht_out = 16'($urandom);
      step(lo);
   endtask

   // Full-scale sample at k=0, then silence except an optional rescue strobe.
   task automatic idle_run(input int rescue);
      valid   = 1'b1;
      lft_out = 16'sd32767;
      rht_out = -16'sd32768;
      for (int k = 1; k <= 66; k++) begin
         @(posedge clk);
         #1;
         valid   = (k == rescue);
         lft_out = 16'sd100;
         rht_out = 16'sd100;
         @(negedge clk);
         if (k == 64) check("idle_k64", LED, 8'hFF);
         if (k >= 65) check("idle_k65", LED, (rescue != 0) ? 8'hFF : 8'h00);
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   function automatic logic signed [15:0] rnd_smp();
      logic signed [15:0] v;
      v = 16'($urandom);
      v = v >>> $urandom_range(0, 14);
      if ($urandom_range(0, 15) == 0) v = -16'sd32768;
      return v;
   endfunction

   int exp_dec[6]   = '{14000, 12250, 10719, 9380, 8208, 7182};
   int exp_small[6] = '{4, 3, 2, 1, 0, 0};
   int n0;

   initial begin
      rst     = 1'b1;
      valid   = 1'b0;
      lft_out = '0;
      rht_out = '0;

      // Reset for two edges with valid toggling.
      step(1);
      valid = 1'b1;
      @(negedge clk);
      check("rst_led", LED, 8'h00);
      @(posedge clk);
      #1;

      // First strobe right after release: 3-cycle latency to LED.
      rst     = 1'b0;
      valid   = 1'b1;
      lft_out = 16'sd16000;
      rht_out = -16'sd32768;
      @(negedge clk);
      check("lat_t0", LED, 8'h00);
      @(posedge clk);
      #1;
      valid = 1'b0;
      @(negedge clk);
      check("lat_t1", LED, 8'h00);
      @(posedge clk);
      @(negedge clk);
      check("lat_t2", LED, 8'h00);
      @(posedge clk);
      @(negedge clk);
      check("lat_t3", LED, 8'h7F);
      @(posedge clk);
      #1;

      // Decay of the 16000 peak through six decay events.
      lhist.delete();
      while (nsmp < 1535) send(0, 0, 1, 1);
      step(3);
      @(negedge clk);
      check("decay5_left", LED[7:4], 4'b0111);
      @(posedge clk);
      #1;
      send(0, 0, 1, 3);
      @(negedge clk);
      check("decay6_left", LED[7:4], 4'b0011);
      check("decay_count", lhist.size(), 6);
      for (int i = 0; i < 6 && i < lhist.size(); i++) check("decay_seq", lhist[i], exp_dec[i]);
      @(posedge clk);
      #1;

      // Level held high is one sample only.
      n0 = nsmp;
      send(3000, 3000, 100, 2);
      check("held_once", nsmp, n0 + 1);

      // New sample beats the decayed peak on a decay-event sample.
      send(9000, 0, 1, 1);
      for (int i = 0; i < 600 && (nsmp % DECAY_SMPLS) != DECAY_SMPLS - 1; i++) send(0, 0, 1, 1);
      send(8500, 0, 1, 3);
      @(negedge clk);
      check("dec_win_led", LED[7:4], 4'b0111);
      check("dec_win_model", lpk, 8500);
      @(posedge clk);
      #1;

      // Idle blanking, then rescue strobes on cycles 63 and 64.
      idle_run(0);
      idle_run(63);
      idle_run(64);
      step(70);

      // Small peak decays by one per event and stops at zero.
      lhist.delete();
      send(5, 3, 1, 1);
      for (int i = 0; i < 2000 && lhist.size() < 6; i++) send(0, 0, 1, 1);
      check("small_count", lhist.size(), 6);
      for (int i = 0; i < 6 && i < lhist.size(); i++) check("small_seq", lhist[i], exp_small[i]);

      // Randomized traffic, idle gaps and in-flight resets.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 19))
            0: begin
               valid   = 1'b1;
               lft_out = rnd_smp();
               rht_out = rnd_smp();
               step(1);
               rst   = 1'b1;
               valid = 1'($urandom);
               step(1);
               rst   = 1'b0;
               valid = 1'b0;
               step(1);
            end
            1:       send(rnd_smp(), rnd_smp(), 1, $urandom_range(60, 70));
            default: send(rnd_smp(), rnd_smp(), $urandom_range(1, 4), $urandom_range(1, 5));
         endcase
      end

      step(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
